// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures operands and opcode; stage 2 holds the result and flags.
module alu_pipe #(
  parameter int              N_BUS  = 8,
  parameter int              N_OP   = 6,
  parameter logic [N_OP-1:0] OP_ADD = 6'b100000,
  parameter logic [N_OP-1:0] OP_SUB = 6'b100010,
  parameter logic [N_OP-1:0] OP_AND = 6'b100100,
  parameter logic [N_OP-1:0] OP_OR  = 6'b100101,
  parameter logic [N_OP-1:0] OP_XOR = 6'b100110,
  parameter logic [N_OP-1:0] OP_NOR = 6'b100111,
  parameter logic [N_OP-1:0] OP_SRA = 6'b000011,
  parameter logic [N_OP-1:0] OP_SRL = 6'b000010,
  parameter logic [N_OP-1:0] OP_SLL = 6'b000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N_BUS-1:0] i_A,
  input  logic [N_BUS-1:0] i_B,
  input  logic [N_OP-1:0]  i_OP,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N_BUS-1:0] o_RES,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_err
);

  typedef struct packed {
    logic [N_BUS-1:0] res;
    logic             carry;
    logic             ovf;
    logic             err;
  } alu_t;

  // Result and carry/overflow/error for one operation. B is read as an
  // unsigned shift amount; amounts of N_BUS or more saturate to a full fill.
  function automatic alu_t alu_eval(input logic signed [N_BUS-1:0] a,
                                    input logic signed [N_BUS-1:0] b,
                                    input logic [N_OP-1:0]         op);
    alu_t           r;
    logic [N_BUS:0] ext;
    logic           big;
    r   = '0;
    ext = '0;
    big = ({32'd0, $unsigned(b)} >= {{N_BUS{1'b0}}, 32'(N_BUS)});
    case (op)
      OP_ADD: begin
        ext     = {1'b0, a} + {1'b0, b};
        r.res   = ext[N_BUS-1:0];
        r.carry = ext[N_BUS];
        r.ovf   = (a[N_BUS-1] == b[N_BUS-1]) && (ext[N_BUS-1] != a[N_BUS-1]);
      end
      OP_SUB: begin
        ext     = {1'b0, a} - {1'b0, b};
        r.res   = ext[N_BUS-1:0];
        r.carry = ext[N_BUS];
        r.ovf   = (a[N_BUS-1] != b[N_BUS-1]) && (ext[N_BUS-1] != a[N_BUS-1]);
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_NOR: r.res = ~(a | b);
      OP_SRA: r.res = big ? {N_BUS{a[N_BUS-1]}} : $unsigned(a >>> $unsigned(b));
      OP_SRL: r.res = big ? '0 : ($unsigned(a) >> $unsigned(b));
      OP_SLL: r.res = big ? '0 : ($unsigned(a) << $unsigned(b));
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  logic                    vld_p1;
  logic signed [N_BUS-1:0] a_p1;
  logic signed [N_BUS-1:0] b_p1;
  logic [N_OP-1:0]         op_p1;

  logic                    vld_p2;
  logic [N_BUS-1:0]        res_p2;
  logic                    zero_p2;
  logic                    neg_p2;
  logic                    carry_p2;
  logic                    ovf_p2;
  logic                    err_p2;

  logic                    in_xfer;
  logic                    adv_p2;
  alu_t                    alu_p1;

  assign o_ready = ~vld_p1 | ~vld_p2 | i_ready;
  assign in_xfer = i_valid & o_ready;
  assign adv_p2  = vld_p1 & (~vld_p2 | i_ready);
  assign alu_p1  = alu_eval(a_p1, b_p1, op_p1);

  // ---- stage 1: operand capture ----
  // Stage 1 occupancy: fill on input transfer, empty when it advances alone.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      vld_p1 <= 1'b0;
    else if (in_xfer) vld_p1 <= 1'b1;
    else if (adv_p2)  vld_p1 <= 1'b0;
  end

  // Stage 1 operands; only meaningful while vld_p1 is set.
  always_ff @(posedge i_clk) begin
    if (in_xfer) begin
      a_p1  <= $signed(i_A);
      b_p1  <= $signed(i_B);
      op_p1 <= i_OP;
    end
  end

  // ---- stage 2: result and flags ----
  // Stage 2 loads from stage 1 when free or draining; holds under back-pressure.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_p2   <= 1'b0;
      res_p2   <= '0;
      zero_p2  <= 1'b0;
      neg_p2   <= 1'b0;
      carry_p2 <= 1'b0;
      ovf_p2   <= 1'b0;
      err_p2   <= 1'b0;
    end else if (adv_p2) begin
      vld_p2   <= 1'b1;
      res_p2   <= alu_p1.res;
      zero_p2  <= (alu_p1.res == '0);
      neg_p2   <= alu_p1.res[N_BUS-1];
      carry_p2 <= alu_p1.carry;
      ovf_p2   <= alu_p1.ovf;
      err_p2   <= alu_p1.err;
    end else if (i_ready) begin
      vld_p2   <= 1'b0;
    end
  end

  assign o_valid = vld_p2;
  assign o_RES   = res_p2;
  assign o_zero  = zero_p2;
  assign o_neg   = neg_p2;
  assign o_carry = carry_p2;
  assign o_ovf   = ovf_p2;
  assign o_err   = err_p2;

endmodule
